// File: rtl/ldw_pkg.sv
// Shared definitions for the ldw CPU memory stage: size encodings, MEM FSM states,
// the latched bus payload and the misalignment rule.
package ldw_pkg;

    localparam logic [1:0] SIZE_B = 2'b00;
    localparam logic [1:0] SIZE_H = 2'b01;
    localparam logic [1:0] SIZE_W = 2'b10;

    localparam int unsigned TIMEOUT_DEF = 255;
    localparam int unsigned CNT_W       = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUS  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic        we;
    } bus_req_t;

    // Size 11 falls into the word rule.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] lane);
        case (size)
            SIZE_B:  return 1'b0;
            SIZE_H:  return lane[0];
            default: return lane != 2'b00;
        endcase
    endfunction

endpackage

// File: rtl/ldw_mem_align.sv
// Byte-lane logic for the MEM stage: store replication and byte enables,
// little-endian load extraction with zero/sign extension.
module ldw_mem_align
    import ldw_pkg::*;
(
    input  logic [1:0]  size,
    input  logic        sext,
    input  logic [1:0]  lane,
    input  logic [31:0] sdata,
    input  logic [31:0] rdata,
    output logic [31:0] wdata,
    output logic [3:0]  be,
    output logic [31:0] ldata
);

    logic [7:0]  rbyte;
    logic [15:0] rhalf;

    always_comb begin
        rbyte = rdata[{lane, 3'b000} +: 8];
        rhalf = lane[1] ? rdata[31:16] : rdata[15:0];
        wdata = sdata;
        be    = 4'b1111;
        ldata = rdata;
        case (size)
            SIZE_B: begin
                wdata = {4{sdata[7:0]}};
                be    = 4'b0001 << lane;
                ldata = {{24{sext & rbyte[7]}}, rbyte};
            end
            SIZE_H: begin
                wdata = {2{sdata[15:0]}};
                be    = lane[1] ? 4'b1100 : 4'b0011;
                ldata = {{16{sext & rhalf[15]}}, rhalf};
            end
            default: begin
                wdata = sdata;
                be    = 4'b1111;
                ldata = rdata;
            end
        endcase
    end

endmodule

// File: rtl/ldw_mem_stage.sv
// ldw MEM stage: issues single-beat data-memory transactions for loads/stores,
// stalls upstream until acknowledge or timeout, and feeds the MEM/WB register.
module ldw_mem_stage
    import ldw_pkg::*;
#(
    parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
    input  logic        clk,
    input  logic        clrn,
    input  logic        mwreg_i,
    input  logic        mm2reg_i,
    input  logic        mwmem,
    input  logic [1:0]  msize,
    input  logic        msext,
    input  logic [31:0] malu_i,
    input  logic [31:0] mb,
    input  logic [4:0]  mrn_i,
    output logic        mwreg_o,
    output logic        mm2reg_o,
    output logic [31:0] mmo,
    output logic [31:0] malu_o,
    output logic [4:0]  mrn_o,
    output logic        stall,
    output logic        mexc,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    output logic [3:0]  bus_be,
    input  logic        bus_ack,
    input  logic [31:0] bus_rdata
);

    localparam logic [1:0] IDLE = ST_IDLE;
    localparam logic [1:0] BUS  = ST_BUS;
    localparam logic [1:0] DONE = ST_DONE;

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_q, err_d;
    logic [31:0]      load_q, load_d;
    bus_req_t         breq_q, breq_d;
    logic [1:0]       size_q, size_d;
    logic [1:0]       lane_q, lane_d;
    logic             sext_q, sext_d;

    logic        in_idle, in_bus, in_done;
    logic        memop, misaligned, access;
    logic [1:0]  al_size, al_lane;
    logic        al_sext;
    logic [31:0] al_wdata, al_ldata;
    logic [3:0]  al_be;

    assign in_idle    = state_q == IDLE;
    assign in_bus     = state_q == BUS;
    assign in_done    = state_q == DONE;
    assign memop      = mm2reg_i | mwmem;
    assign misaligned = memop & is_misaligned(msize, malu_i[1:0]);
    assign access     = memop & ~misaligned;

    // Live operands steer the store in IDLE; latched ones format the load in BUS.
    assign al_size = in_idle ? msize        : size_q;
    assign al_lane = in_idle ? malu_i[1:0]  : lane_q;
    assign al_sext = in_idle ? msext        : sext_q;

    ldw_mem_align u_align (
        .size  (al_size),
        .sext  (al_sext),
        .lane  (al_lane),
        .sdata (mb),
        .rdata (bus_rdata),
        .wdata (al_wdata),
        .be    (al_be),
        .ldata (al_ldata)
    );

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            err_q   <= 1'b0;
            load_q  <= '0;
            breq_q  <= '0;
            size_q  <= '0;
            lane_q  <= '0;
            sext_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            load_q  <= load_d;
            breq_q  <= breq_d;
            size_q  <= size_d;
            lane_q  <= lane_d;
            sext_q  <= sext_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        load_d  = load_q;
        breq_d  = breq_q;
        size_d  = size_q;
        lane_d  = lane_q;
        sext_d  = sext_q;
        case (state_q)
            IDLE: begin
                if (access) begin
                    breq_d.addr  = {malu_i[31:2], 2'b00};
                    breq_d.wdata = al_wdata;
                    breq_d.be    = al_be;
                    breq_d.we    = mwmem;
                    size_d       = msize;
                    lane_d       = malu_i[1:0];
                    sext_d       = msext;
                    cnt_d        = '0;
                    err_d        = 1'b0;
                    state_d      = BUS;
                end
            end
            BUS: begin
                // Ack is checked first so a last-cycle ack beats the timeout.
                if (bus_ack) begin
                    load_d  = al_ldata;
                    state_d = DONE;
                end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    err_d   = 1'b1;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            DONE: begin
                cnt_d   = '0;
                err_d   = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign stall     = clrn & ((in_idle & access) | in_bus);
    assign mexc      = clrn & ((in_idle & misaligned) | (in_done & err_q));
    assign mwreg_o   = clrn & mwreg_i & ~misaligned & ~(in_done & err_q);
    assign mmo       = in_done ? load_q : 32'd0;
    assign mm2reg_o  = mm2reg_i;
    assign malu_o    = malu_i;
    assign mrn_o     = mrn_i;

    assign bus_req   = in_bus;
    assign bus_we    = in_bus & breq_q.we;
    assign bus_addr  = breq_q.addr;
    assign bus_wdata = breq_q.wdata;
    assign bus_be    = breq_q.be;

endmodule

// File: tb/tb_ldw_mem_stage.sv
// Directed bench for ldw_mem_stage: expected transactions are queued as each
// operation is driven and checked when the stage finishes it.
module tb_ldw_mem_stage;
    import ldw_pkg::*;

    localparam int unsigned TO = 4;

    logic        clk = 1'b0;
    logic        clrn;
    logic        mwreg_i, mm2reg_i, mwmem, msext;
    logic [1:0]  msize;
    logic [31:0] malu_i, mb;
    logic [4:0]  mrn_i;
    logic        mwreg_o, mm2reg_o, stall, mexc;
    logic [31:0] mmo, malu_o;
    logic [4:0]  mrn_o;
    logic        bus_req, bus_we, bus_ack;
    logic [31:0] bus_addr, bus_wdata, bus_rdata;
    logic [3:0]  bus_be;

    always #5 clk = ~clk;

    ldw_mem_stage #(.TIMEOUT(TO)) dut (
        .clk(clk), .clrn(clrn),
        .mwreg_i(mwreg_i), .mm2reg_i(mm2reg_i), .mwmem(mwmem),
        .msize(msize), .msext(msext), .malu_i(malu_i), .mb(mb), .mrn_i(mrn_i),
        .mwreg_o(mwreg_o), .mm2reg_o(mm2reg_o), .mmo(mmo), .malu_o(malu_o),
        .mrn_o(mrn_o), .stall(stall), .mexc(mexc),
        .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
        .bus_wdata(bus_wdata), .bus_be(bus_be),
        .bus_ack(bus_ack), .bus_rdata(bus_rdata)
    );

    typedef struct packed {
        logic [7:0]  nreq;
        logic [7:0]  stalls;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic        we;
        logic        chk_mmo;
        logic [31:0] mmo;
        logic        mexc;
        logic        mwreg;
    } exp_t;

    exp_t sb[$];
    int   n_chk  = 0;
    int   n_fail = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    function automatic exp_t mk(input int nreq, input int stalls, input logic [31:0] addr,
                                input logic [31:0] wdata, input logic [3:0] be, input logic we,
                                input logic chk_mmo, input logic [31:0] m,
                                input logic x, input logic wr);
        exp_t e;
        e.nreq = 8'(nreq); e.stalls = 8'(stalls); e.addr = addr; e.wdata = wdata;
        e.be = be; e.we = we; e.chk_mmo = chk_mmo; e.mmo = m; e.mexc = x; e.mwreg = wr;
        return e;
    endfunction

    task automatic drive_nop();
        mwreg_i = 1'b0; mm2reg_i = 1'b0; mwmem = 1'b0; msize = SIZE_W; msext = 1'b0;
        malu_i = 32'd0; mb = 32'd0; mrn_i = 5'd0; bus_ack = 1'b0; bus_rdata = 32'd0;
    endtask

    // Called at posedge+1 with the stage in IDLE; returns at posedge+1 after completion.
    // ack_at: index of the BUS cycle that gets bus_ack (-1 = never).
    task automatic mem_op(input string tag, input logic ld, input logic st, input logic wr,
                          input logic [1:0] sz, input logic sx, input logic [31:0] alu,
                          input logic [31:0] b, input int ack_at, input logic [31:0] rd,
                          input exp_t e);
        exp_t        x;
        int          stalls = 0, bus_cyc = 0;
        bit          done = 1'b0;
        logic [31:0] a_addr = '0, a_wdata = '0, f_mmo = '0;
        logic [3:0]  a_be = '0;
        logic        a_we = 1'b0, f_mexc = 1'b0, f_wreg = 1'b0, f_m2r = 1'b0;
        logic [4:0]  f_rn = '0;
        logic [31:0] f_alu = '0;
        sb.push_back(e);
        mwreg_i = wr; mm2reg_i = ld; mwmem = st; msize = sz; msext = sx;
        malu_i = alu; mb = b; mrn_i = alu[4:0] ^ 5'h15;
        for (int c = 0; c < 64 && !done; c++) begin
            bus_ack   = bus_req && (bus_cyc == ack_at);
            bus_rdata = bus_ack ? rd : 32'h5A5A_A5A5;
            @(negedge clk);
            if (bus_req) begin
                if (bus_cyc == 0) begin
                    a_addr = bus_addr; a_wdata = bus_wdata; a_be = bus_be; a_we = bus_we;
                end
                bus_cyc++;
            end
            if (stall) stalls++;
            else begin
                f_mmo = mmo; f_mexc = mexc; f_wreg = mwreg_o;
                f_m2r = mm2reg_o; f_rn = mrn_o; f_alu = malu_o;
                done = 1'b1;
            end
            @(posedge clk); #1;
        end
        bus_ack = 1'b0;
        x = sb.pop_front();
        check({tag, ".finished"}, 32'(done), 32'd1);
        check({tag, ".stall_cycles"}, 32'(stalls), 32'(x.stalls));
        check({tag, ".req_cycles"}, 32'(bus_cyc), 32'(x.nreq));
        if (x.nreq != 0) begin
            check({tag, ".addr"}, a_addr, x.addr);
            check({tag, ".we"}, 32'(a_we), 32'(x.we));
            if (x.we) begin
                check({tag, ".wdata"}, a_wdata, x.wdata);
                check({tag, ".be"}, 32'(a_be), 32'(x.be));
            end
        end
        if (x.chk_mmo) check({tag, ".mmo"}, f_mmo, x.mmo);
        check({tag, ".mexc"}, 32'(f_mexc), 32'(x.mexc));
        check({tag, ".mwreg_o"}, 32'(f_wreg), 32'(x.mwreg));
        check({tag, ".passthru"}, {f_alu[26:0], f_rn}, {alu[26:0], alu[4:0] ^ 5'h15});
        check({tag, ".mm2reg_o"}, 32'(f_m2r), 32'(ld));
        drive_nop();
    endtask

    initial begin
        drive_nop();
        clrn = 1'b0;
        // Reset with a load presented: nothing may escape.
        mm2reg_i = 1'b1; mwreg_i = 1'b1; malu_i = 32'h100;
        #3;
        check("rst.stall", 32'(stall), 32'd0);
        check("rst.mwreg_o", 32'(mwreg_o), 32'd0);
        check("rst.bus_req", 32'(bus_req), 32'd0);
        check("rst.mexc", 32'(mexc), 32'd0);
        check("rst.bus_addr", bus_addr, 32'd0);
        check("rst.bus_be", 32'(bus_be), 32'd0);
        check("rst.mmo", mmo, 32'd0);
        drive_nop();
        @(negedge clk); clrn = 1'b1;
        @(posedge clk); #1;

        mem_op("sw", 0, 1, 0, SIZE_W, 0, 32'h100, 32'hDEADBEEF, 2, 32'h0,
               mk(3, 4, 32'h100, 32'hDEADBEEF, 4'hF, 1, 1, 32'h0, 0, 0));
        mem_op("lb_sext", 1, 0, 1, SIZE_B, 1, 32'h103, 32'h0, 0, 32'h80FF1234,
               mk(1, 2, 32'h100, 32'h0, 4'h0, 0, 1, 32'hFFFFFF80, 0, 1));
        mem_op("lbu", 1, 0, 1, SIZE_B, 0, 32'h103, 32'h0, 0, 32'h80FF1234,
               mk(1, 2, 32'h100, 32'h0, 4'h0, 0, 1, 32'h00000080, 0, 1));
        mem_op("sh", 0, 1, 0, SIZE_H, 0, 32'h22, 32'h0000ABCD, 1, 32'h0,
               mk(2, 3, 32'h20, 32'hABCDABCD, 4'hC, 1, 1, 32'h0, 0, 0));
        mem_op("sb", 0, 1, 0, SIZE_B, 0, 32'h101, 32'h12345678, 0, 32'h0,
               mk(1, 2, 32'h100, 32'h78787878, 4'h2, 1, 1, 32'h0, 0, 0));
        mem_op("lh_sext", 1, 0, 1, SIZE_H, 1, 32'h102, 32'h0, 1, 32'h80FF1234,
               mk(2, 3, 32'h100, 32'h0, 4'h0, 0, 1, 32'hFFFF80FF, 0, 1));
        mem_op("lhu", 1, 0, 1, SIZE_H, 0, 32'h100, 32'h0, 0, 32'h80FF1234,
               mk(1, 2, 32'h100, 32'h0, 4'h0, 0, 1, 32'h00001234, 0, 1));
        mem_op("lw_misal", 1, 0, 1, SIZE_W, 0, 32'h102, 32'h0, 0, 32'h0,
               mk(0, 0, 32'h0, 32'h0, 4'h0, 0, 1, 32'h0, 1, 0));
        mem_op("sh_misal", 0, 1, 0, SIZE_H, 0, 32'h21, 32'h1111, 0, 32'h0,
               mk(0, 0, 32'h0, 32'h0, 4'h0, 0, 1, 32'h0, 1, 0));
        mem_op("lw_timeout", 1, 0, 1, SIZE_W, 0, 32'h40, 32'h0, -1, 32'h0,
               mk(TO, TO + 1, 32'h40, 32'h0, 4'h0, 0, 0, 32'h0, 1, 0));
        mem_op("lw_ack_last", 1, 0, 1, SIZE_W, 0, 32'h44, 32'h0, TO - 1, 32'hCAFEF00D,
               mk(TO, TO + 1, 32'h44, 32'h0, 4'h0, 0, 1, 32'hCAFEF00D, 0, 1));
        mem_op("lw_size3", 1, 0, 1, 2'b11, 0, 32'h48, 32'h0, 0, 32'h01234567,
               mk(1, 2, 32'h48, 32'h0, 4'h0, 0, 1, 32'h01234567, 0, 1));
        mem_op("alu_op", 0, 0, 1, SIZE_W, 0, 32'h100, 32'h0, 0, 32'h0,
               mk(0, 0, 32'h0, 32'h0, 4'h0, 0, 1, 32'h0, 0, 1));

        // Stray acknowledge while idle must be ignored.
        bus_ack = 1'b1; bus_rdata = 32'hFFFFFFFF;
        @(negedge clk);
        check("stray_ack.stall", 32'(stall), 32'd0);
        check("stray_ack.bus_req", 32'(bus_req), 32'd0);
        @(posedge clk); #1;
        bus_ack = 1'b0;
        @(negedge clk);
        check("stray_ack.mmo", mmo, 32'd0);
        check("stray_ack.req_after", 32'(bus_req), 32'd0);
        @(posedge clk); #1;

        // Reset in the second BUS cycle abandons the access immediately.
        mm2reg_i = 1'b1; mwreg_i = 1'b1; msize = SIZE_W; malu_i = 32'h200;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("midrst.req_before", 32'(bus_req), 32'd1);
        #2 clrn = 1'b0;
        #1;
        check("midrst.bus_req", 32'(bus_req), 32'd0);
        check("midrst.stall", 32'(stall), 32'd0);
        check("midrst.mwreg_o", 32'(mwreg_o), 32'd0);
        check("midrst.bus_addr", bus_addr, 32'd0);
        drive_nop();
        @(negedge clk); clrn = 1'b1;
        @(posedge clk); #1;
        check("midrst.idle_req", 32'(bus_req), 32'd0);

        mem_op("lw_after_rst", 1, 0, 1, SIZE_W, 0, 32'h80, 32'h0, 0, 32'h13579BDF,
               mk(1, 2, 32'h80, 32'h0, 4'h0, 0, 1, 32'h13579BDF, 0, 1));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/ldw_mem_stage.md
# ldw_mem_stage

Pipeline MEM stage of the ldw five-stage CPU. It sits between the EX/MEM pipeline register and the MEM/WB register. It turns load/store requests into single-beat transactions on the data-memory bus, handles byte/half/word lane steering and extension, and stalls the pipeline until the bus acknowledges. Its outputs are the `m*` inputs of the MEM/WB register.

## Interface
Parameters:
- TIMEOUT, 255: maximum cycles in BUS before the access is aborted (1..255).

Ports:
- clk  in  1  clock.
- clrn  in  1  asynchronous active-low reset.
- mwreg_i  in  1  register-write request from EX/MEM.
- mm2reg_i  in  1  load (result comes from memory).
- mwmem  in  1  store.
- msize  in  2  access size: 00 byte, 01 half, 10 word; 11 is treated as word.
- msext  in  1  sign-extend a byte/half load.
- malu_i  in  32  ALU result, which is also the effective address.
- mb  in  32  store data.
- mrn_i  in  5  destination register.
- mwreg_o  out  1  gated write-enable to MEM/WB.
- mm2reg_o  out  1  pass-through of mm2reg_i.
- mmo  out  32  formatted load data.
- malu_o  out  32  pass-through of malu_i.
- mrn_o  out  5  pass-through of mrn_i.
- stall  out  1  freezes PC, IF/ID, ID/EX and EX/MEM; MEM/WB loads a bubble while high.
- mexc  out  1  one-cycle pulse: misaligned access or bus timeout.
- bus_req, bus_we  out  1  request and write strobe.
- bus_addr  out  32  word-aligned address ({addr[31:2],2'b00}).
- bus_wdata  out  32  lane-steered store data.
- bus_be  out  4  byte enables.
- bus_ack  in  1  one-cycle acknowledge.
- bus_rdata  in  32  read data, valid with bus_ack.

## Operation
- Misaligned when half and addr[0]=1, or word and addr[1:0]≠00.
- access = (mm2reg_i | mwmem) & ~misaligned.
- A misaligned access issues no bus cycle and adds no stall. In that cycle: mexc=1 and mwreg_o=0.
- FSM states: IDLE, BUS, DONE.
  - IDLE: if access, register the address, wdata, be, we and size/sext, then go to BUS. Otherwise stay in IDLE.
  - BUS: bus_req=1, bus_we=mwmem. On bus_ack, capture the formatted rdata into load_q and go to DONE. If the wait counter reaches TIMEOUT without an ack, go to DONE with the error flag set.
  - DONE: always return to IDLE.
- stall = (IDLE & access) | BUS. stall is 0 in DONE.
- While stall is high, upstream holds its inputs stable.
- mmo = load_q in DONE, else 0. mwreg_o = mwreg_i & ~misaligned & ~err.
- Non-memory operations pass through with no stall.
- Store lanes:
  - sb: replicate byte ×4; be = 0001 << addr[1:0].
  - sh: replicate half ×2; be = addr[1] ? 1100 : 0011.
  - sw: be = 1111.
- Loads are little-endian. Take the byte/half selected by addr[1:0], then zero- or sign-extend per msext.

## Timing
- Aligned memory operation: at least 3 cycles (IDLE, BUS with same-cycle ack, DONE). Each ack wait cycle adds 1.
- MEM/WB captures the result at the end of DONE.
- Timeout: after TIMEOUT cycles in BUS, bus_req drops and DONE asserts mexc=1 with mwreg_o=0.
- If bus_ack arrives in the same cycle the counter reaches TIMEOUT, the ack wins and no error is raised.
- bus_ack outside BUS is ignored.
- Reset values: state=IDLE, counter=0, load_q=0, all registered bus outputs 0, mexc=0.
- While clrn=0, stall=0 and mwreg_o=0.
- Reset asserted mid-BUS drops bus_req asynchronously and abandons the access.

## Structure
- Shared package ldw_pkg holds:
  - SIZE_B/SIZE_H/SIZE_W encodings
  - state enum
  - default TIMEOUT
- Combinational sub-module ldw_mem_align does store lane steering/be and load extraction/extension. The FSM, counter and registers stay in ldw_mem_stage.

## Test plan
- sw mb=0xDEADBEEF @0x100, ack 2 cycles after req → bus_addr=0x100, be=1111, wdata=0xDEADBEEF; stall high for 4 cycles; mexc=0.
- lb @0x103, rdata=0x80FF1234, msext=1 → mmo=0xFFFFFF80 in DONE; with msext=0 → mmo=0x00000080.
- sh mb=0x0000ABCD @0x22 → be=1100, wdata=0xABCDABCD.
- lw @0x102 → no bus_req, stall=0, mexc pulse, mwreg_o=0.
- lw with no ack, TIMEOUT=4 → bus_req high for exactly 4 cycles, then DONE with mexc=1 and mwreg_o=0; stall released next cycle.
- clrn low in cycle 2 of BUS → bus_req=0 immediately, state IDLE, load_q=0. A following lw completes normally.
